// File: rtl/csa_stream_accumulator.sv
// Packet accumulator: the running total is kept in carry-save form (S, C) and
// resolved with a single carry-propagate add after the packet's last operand.
module csa_stream_accumulator #(
    parameter int N      = 32,
    parameter int G      = 4,
    parameter int SIGNED = 1,
    parameter int CW     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in1,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N+G-1:0]   sum,
    output logic [CW-1:0]    count,
    output logic             of,
    output logic [1:0]       state_o
);

    localparam int ACC_W = N + G;

    localparam logic [1:0] ST_ACC     = 2'd0;
    localparam logic [1:0] ST_RESOLVE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    // Count value whose acceptance of one more operand exceeds the guard range.
    localparam logic [CW-1:0] GUARD_CNT = CW'(2 ** G);

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] s_q, s_d;
    logic [ACC_W-1:0] c_q, c_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CW-1:0]    count_q, count_d;
    logic             of_q, of_d;

    logic [ACC_W-1:0] x;
    logic [ACC_W-1:0] maj;

    generate
        if (SIGNED != 0) begin : g_sext
            assign x = {{G{in1[N-1]}}, in1};
        end else begin : g_zext
            assign x = {{G{1'b0}}, in1};
        end
    endgenerate

    assign maj = (s_q & c_q) | (s_q & x) | (c_q & x);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready never depends on valid, and both are decoded from state_q.
    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign count     = count_q;
    assign of        = of_q;
    assign state_o   = state_q;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        sum_d   = sum_q;
        count_d = count_q;
        of_d    = of_q;
        if (clr) begin
            state_d = ST_ACC;
            s_d     = '0;
            c_d     = '0;
            count_d = '0;
            of_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (in_valid) begin
                        s_d = s_q ^ c_q ^ x;
                        c_d = {maj[ACC_W-2:0], 1'b0};
                        if (count_q != '1) begin
                            count_d = count_q + CW'(1);
                        end
                        of_d = of_q | (count_q == GUARD_CNT);
                        if (in_last) begin
                            state_d = ST_RESOLVE;
                        end
                    end
                end
                ST_RESOLVE: begin
                    sum_d   = s_q + c_q;
                    s_d     = '0;
                    c_d     = '0;
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_ACC;
                        count_d = '0;
                        of_d    = 1'b0;
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            s_q     <= '0;
            c_q     <= '0;
            sum_q   <= '0;
            count_q <= '0;
            of_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            of_q    <= of_d;
        end
    end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Bench for csa_stream_accumulator: a signed and an unsigned instance share one
// input stream; packet results are checked against an integer-sum model.
module tb_csa_stream_accumulator;

    localparam int N     = 8;
    localparam int G     = 4;
    localparam int CW    = 16;
    localparam int ACC_W = N + G;
    localparam int EXP_W = 1 + CW + 2 * ACC_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             out_ready = 1'b0;
    logic [N-1:0]     in1 = '0;

    logic             in_ready_s, in_ready_u, out_valid_s, out_valid_u, of_s, of_u;
    logic [ACC_W-1:0] sum_s, sum_u;
    logic [CW-1:0]    count_s, count_u;
    logic [1:0]       state_s, state_u;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int first_acc = 0;
    int last_acc  = 0;
    int prev_last = 0;

    // Expected packet results: {of, count, unsigned sum, signed sum}.
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] e_mon;
    logic [N-1:0]     pkt_q[$];

    csa_stream_accumulator #(.N(N), .G(G), .SIGNED(1), .CW(CW)) dut_s (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_s),
        .in1(in1), .in_last(in_last), .out_valid(out_valid_s), .out_ready(out_ready),
        .sum(sum_s), .count(count_s), .of(of_s), .state_o(state_s)
    );

    csa_stream_accumulator #(.N(N), .G(G), .SIGNED(0), .CW(CW)) dut_u (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_u),
        .in1(in1), .in_last(in_last), .out_valid(out_valid_u), .out_ready(out_ready),
        .sum(sum_u), .count(count_u), .of(of_u), .state_o(state_u)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer sums of the packet, reduced modulo 2^ACC_W.
    function automatic logic [EXP_W-1:0] model_pkt();
        int acc_s = 0;
        int acc_u = 0;
        int n;
        logic [ACC_W-1:0] rs, ru;
        logic [CW-1:0]    rc;
        logic             rof;
        n = pkt_q.size();
        foreach (pkt_q[i]) begin
            acc_s += int'($signed(pkt_q[i]));
            acc_u += int'(pkt_q[i]);
        end
        rs  = acc_s[ACC_W-1:0];
        ru  = acc_u[ACC_W-1:0];
        rc  = (n > 65535) ? 16'hFFFF : n[CW-1:0];
        rof = (n > (1 << G));
        return {rof, rc, ru, rs};
    endfunction

    // scoreboard: compare every result handshake against the head of exp_q
    always begin
        @(negedge clk);
        #2;
        if (rst_n && out_valid_s && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(out_valid_s), 64'(0));
            end else begin
                e_mon = exp_q.pop_front();
                check("sum_signed", 64'(sum_s), 64'(e_mon[ACC_W-1:0]));
                check("sum_unsigned", 64'(sum_u), 64'(e_mon[2*ACC_W-1:ACC_W]));
                check("count_s", 64'(count_s), 64'(e_mon[2*ACC_W+CW-1:2*ACC_W]));
                check("count_u", 64'(count_u), 64'(e_mon[2*ACC_W+CW-1:2*ACC_W]));
                check("of_s", 64'(of_s), 64'(e_mon[EXP_W-1]));
                check("of_u", 64'(of_u), 64'(e_mon[EXP_W-1]));
                check("out_valid_u", 64'(out_valid_u), 64'(1));
            end
        end
    end

    // driver: present pkt_q one operand per accept; in_valid stays high at return
    task automatic send_pkt(input bit expect_result, input bit bubbles);
        int guard;
        if (expect_result) exp_q.push_back(model_pkt());
        for (int i = 0; i < pkt_q.size(); i++) begin
            if (bubbles && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_last  = 1'b1;
                in1      = 8'($urandom);
            end
            @(negedge clk);
            in_valid = 1'b1;
            in1      = pkt_q[i];
            in_last  = (i == pkt_q.size() - 1);
            guard    = 0;
            while (!in_ready_s && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) check("accept_timeout", 64'(in_ready_s), 64'(1));
            @(posedge clk);
            if (i == 0) first_acc = cyc;
            last_acc = cyc;
        end
    endtask

    task automatic take_result(input int delay);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        while (!out_valid_s && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!out_valid_s) check("result_timeout", 64'(out_valid_s), 64'(1));
        repeat (delay) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [EXP_W-1:0] e;
        int guard;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready_s), 64'(1));
        check("rst_in_ready_u", 64'(in_ready_u), 64'(1));
        check("rst_out_valid", 64'(out_valid_s), 64'(0));
        check("rst_sum", 64'(sum_s), 64'(0));
        check("rst_count", 64'(count_s), 64'(0));
        check("rst_of", 64'(of_s), 64'(0));
        rst_n = 1'b1;

        // 3 + 5 + 7 with latency and ready-return checks
        pkt_q = '{8'd3, 8'd5, 8'd7};
        send_pkt(1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("lat_resolve_out_valid", 64'(out_valid_s), 64'(0));
        check("lat_resolve_in_ready", 64'(in_ready_s), 64'(0));
        @(negedge clk);
        check("lat_done_out_valid", 64'(out_valid_s), 64'(1));
        check("lat_done_sum", 64'(sum_s), 64'(12'h00F));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("ready_return", 64'(in_ready_s), 64'(1));
        check("done_exit_out_valid", 64'(out_valid_s), 64'(0));
        check("done_exit_count", 64'(count_s), 64'(0));

        // sign extension
        pkt_q = '{8'hFF, 8'hFE, 8'h01};
        send_pkt(1'b1, 1'b0);
        take_result(0);

        // guard boundary
        pkt_q.delete();
        repeat (16) pkt_q.push_back(8'h7F);
        send_pkt(1'b1, 1'b0);
        take_result(1);
        pkt_q.push_back(8'h7F);
        send_pkt(1'b1, 1'b0);
        take_result(2);

        // backpressure in DONE with an operand waiting, then single-operand packet
        pkt_q = '{8'd1, 8'd2};
        send_pkt(1'b1, 1'b0);
        e = exp_q[exp_q.size() - 1];
        @(negedge clk);
        in_valid = 1'b1;
        in1      = 8'h80;
        in_last  = 1'b1;
        guard    = 0;
        while (!out_valid_s && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", 64'(out_valid_s), 64'(1));
            check("bp_in_ready", 64'(in_ready_s), 64'(0));
            check("bp_sum", 64'(sum_s), 64'(e[ACC_W-1:0]));
            check("bp_count", 64'(count_s), 64'(e[2*ACC_W+CW-1:2*ACC_W]));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        pkt_q = '{8'h80};
        exp_q.push_back(model_pkt());
        check("bp_exit_in_ready", 64'(in_ready_s), 64'(1));
        check("bp_exit_count", 64'(count_s), 64'(0));
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("single_count", 64'(count_s), 64'(1));
        check("single_resolve_out_valid", 64'(out_valid_s), 64'(0));
        @(negedge clk);
        check("single_done_out_valid", 64'(out_valid_s), 64'(1));
        check("single_sum_s", 64'(sum_s), 64'(12'hF80));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // abort with clr; the operand offered alongside clr is dropped
        pkt_q = '{8'd9, 8'd9};
        send_pkt(1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in1      = 8'h33;
        in_last  = 1'b1;
        clr      = 1'b1;
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("clr_count", 64'(count_s), 64'(0));
        check("clr_in_ready", 64'(in_ready_s), 64'(1));
        pkt_q = '{8'd4};
        send_pkt(1'b1, 1'b0);
        take_result(0);

        // abort with asynchronous reset mid-packet
        pkt_q = '{8'd9, 8'd9};
        send_pkt(1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_count", 64'(count_s), 64'(0));
        check("arst_sum", 64'(sum_s), 64'(0));
        check("arst_in_ready", 64'(in_ready_s), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        pkt_q = '{8'd4};
        send_pkt(1'b1, 1'b0);
        take_result(0);

        // back-to-back packets with continuous in_valid
        out_ready = 1'b1;
        pkt_q.delete();
        repeat ($urandom_range(3, 6)) pkt_q.push_back(8'($urandom));
        send_pkt(1'b1, 1'b0);
        prev_last = last_acc;
        pkt_q.delete();
        repeat ($urandom_range(3, 6)) pkt_q.push_back(8'($urandom));
        send_pkt(1'b1, 1'b0);
        check("b2b_gap", 64'(first_acc - prev_last), 64'(3));
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;

        // randomized packets with bubbles and result backpressure
        for (int p = 0; p < 25; p++) begin
            pkt_q.delete();
            repeat ($urandom_range(1, 20)) pkt_q.push_back(8'($urandom));
            send_pkt(1'b1, 1'b1);
            take_result($urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
